mips_muldiv_unit: RTL and testbench
===================================

# mips_muldiv_unit

Parametrised multi-cycle multiply/divide unit with HI/LO result registers for the non-pipelined MIPS datapath. It generalises the single-cycle ALU path to a WIDTH-bit iterative engine. It executes MULT, MULTU, DIV and DIVU over WIDTH+2 cycles behind a start/busy/done handshake. The decode logic launches operations; MFHI/MFLO read `hi`/`lo` directly, and MTHI/MTLO write them through `hi_we`/`lo_we`.

## Interface
- `WIDTH`, 16, operand, HI and LO width; legal range is 4 to 32.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch request; sampled only in IDLE.
- `op`  in  2  operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  WIDTH  multiplicand or dividend (rs); captured on accept.
- `b`  in  WIDTH  multiplier or divisor (rt); captured on accept.
- `hi_we`  in  1  MTHI strobe.
- `lo_we`  in  1  MTLO strobe.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle completion pulse.
- `div_zero`  out  1  divisor was zero; valid while `done` is high.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- FSM states: IDLE, RUN, FIX, DONE.
  - IDLE→RUN when `start` is high.
  - RUN holds for WIDTH cycles, then →FIX.
  - FIX→DONE.
  - DONE→IDLE unconditionally.
- Accept (IDLE with `start`):
  - Latch `op`, `a` and `b`.
  - For signed ops, convert operands to magnitudes and record the result signs.
  - Clear the iteration counter.
- RUN, multiply: shift-add, one multiplier bit per cycle, into a 2·WIDTH product register.
- RUN, divide: restoring division, one quotient bit per cycle; the remainder register is WIDTH+1 bits.
- FIX, result fixups:
  - MULT: negate the 2·WIDTH product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; give the remainder the dividend's sign. Quotient truncates toward zero.
  - Write HI = upper product or remainder; LO = lower product or quotient.
- Divide by zero:
  - No trap; the algorithm runs normally.
  - Result: LO = all ones, HI = dividend (magnitude for DIV, re-signed by the rule above). `div_zero` = 1 with `done`.
- DIV of most-negative by −1: LO = most-negative, HI = 0. No flag.
- `hi_we`/`lo_we`:
  - Honoured only in IDLE; ignored in RUN, FIX and DONE.
  - If asserted in the same IDLE cycle as `start`, the write lands on that edge and the completing operation later overwrites it.
- `start` outside IDLE is ignored; nothing is queued.
- Reset mid-operation aborts immediately. All state and outputs return to reset values.

## Timing
- Reset values: `busy` = 0, `done` = 0, `div_zero` = 0, `hi` = 0, `lo` = 0, state IDLE.
- Latency, with `start` sampled at edge k:
  - `busy` = 1 from after edge k until edge k+WIDTH+2.
  - `hi`/`lo` updated at edge k+WIDTH+1.
  - `done` and `div_zero` high for exactly the cycle after edge k+WIDTH+1 (state DONE).
  - `busy` drops with `done`.
- Back-to-back: the earliest next accept is the edge at the end of the `done` cycle, giving a throughput of one op per WIDTH+2 cycles.
- `hi` and `lo` are stable and readable every cycle outside the FIX edge.

## Configuration
- `MIPS_MULDIV_DIV_EN`.
  - Defined: full behaviour as above.
  - Undefined: the divider datapath is removed. DIV/DIVU are still accepted with normal FSM timing, but `hi`/`lo` stay unchanged and `div_zero` is forced to 0. Multiply behaviour and timing are identical in both builds.

## Structure
- Shared package `mips_pkg` holds:
  - the 2-bit op encodings (`MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`);
  - the FSM state enum;
  - the default datapath width constant (16).
- Sub-module `mips_muldiv_core`: the iterative datapath (operand/product/remainder shift registers, adder/subtractor, counter). It is stepped by enables from the FSM kept in the top level.
- The sign-magnitude conversion and fixup logic stay in the top level.

## Test plan (WIDTH = 16)
- MULTU a=0xFFFF b=0xFFFF → HI=0xFFFE, LO=0x0001; `done` in the cycle after edge k+17; `busy` high for exactly 18 cycles.
- MULT a=0xFFFD (−3) b=0x0005 → HI=0xFFFF, LO=0xFFF1; then MTLO 0x1234 in IDLE → LO=0x1234, HI unchanged.
- DIV a=0xFFF9 (−7) b=0x0002 → LO=0xFFFD, HI=0xFFFF. DIV a=0x8000 b=0xFFFF → LO=0x8000, HI=0x0000.
- DIVU a=0x0064 b=0x0000 → LO=0xFFFF, HI=0x0064, `div_zero`=1 for one cycle. The next normal op reports `div_zero`=0.
- `start` and `hi_we` pulsed mid-RUN are ignored, and the result matches an undisturbed run.
- `reset` low at RUN cycle 7 → `busy`, `hi`, `lo` go to 0 asynchronously. After release, a fresh MULTU 3×4 gives LO=0x000C.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: muldiv op codes, muldiv FSM states
// and the default datapath width.
package mips_pkg;

  localparam int MD_WIDTH_DEF = 16;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_RUN,
    MD_FIX,
    MD_DONE
  } md_state_e;

endpackage

// File: rtl/mips_muldiv_core.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per step.
// Ports: load_i/step_i from FSM, div_i mode, a_i/b_i magnitudes, hi_o/lo_o raw result, last_o.
module mips_muldiv_core
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             last_o
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH+1:0] add_x, add_y, sum;
  logic             add_ci;
`ifdef MIPS_MULDIV_DIV_EN
  logic             div_q, div_d;
`endif

  // One shared adder: product accumulate, or trial subtract
  // (x + ~d + 1) whose top bit is set exactly when x < d.
  always_comb begin
    add_x  = {1'b0, acc_q};
    add_y  = lo_q[0] ? {2'b00, opnd_q} : '0;
    add_ci = 1'b0;
`ifdef MIPS_MULDIV_DIV_EN
    if (div_q) begin
      add_x  = {1'b0, acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
      add_y  = ~{2'b00, opnd_q};
      add_ci = 1'b1;
    end
`endif
    sum = add_x + add_y + {{(WIDTH+1){1'b0}}, add_ci};
  end

  always_comb begin
    acc_d  = acc_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
`ifdef MIPS_MULDIV_DIV_EN
    div_d  = div_q;
`endif
    if (load_i) begin
      acc_d  = '0;
      lo_d   = div_i ? a_i : b_i;
      opnd_d = div_i ? b_i : a_i;
      cnt_d  = '0;
`ifdef MIPS_MULDIV_DIV_EN
      div_d  = div_i;
`endif
    end else if (step_i) begin
      cnt_d = cnt_q + CW'(1);
      acc_d = sum[WIDTH+1:1];
      lo_d  = {sum[0], lo_q[WIDTH-1:1]};
`ifdef MIPS_MULDIV_DIV_EN
      if (div_q) begin
        if (!sum[WIDTH+1]) begin
          acc_d = sum[WIDTH:0];
          lo_d  = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
          lo_d  = {lo_q[WIDTH-2:0], 1'b0};
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q  <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
`ifdef MIPS_MULDIV_DIV_EN
      div_q  <= 1'b0;
`endif
    end else begin
      acc_q  <= acc_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
`ifdef MIPS_MULDIV_DIV_EN
      div_q  <= div_d;
`endif
    end
  end

  assign hi_o   = acc_q[WIDTH-1:0];
  assign lo_o   = lo_q;
  assign last_o = (cnt_q == CW'(WIDTH-1));

endmodule

// File: rtl/mips_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO; divider present only with MIPS_MULDIV_DIV_EN.
// Ports: start/op/a/b launch, hi_we/lo_we/wdata MTHI/MTLO, busy/done/div_zero status, hi/lo.
module mips_muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e state_q, state_d;

  logic             accept, idle;
  logic             sgn_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_q, neg_q, dz_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] core_hi, core_lo;
  logic             core_last;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             res_we, res_dz;
`ifdef MIPS_MULDIV_DIV_EN
  logic             rsgn_q, bz_q;
  logic [WIDTH-1:0] quo, rem;
`endif

  assign idle   = (state_q == MD_IDLE);
  assign accept = idle & start;

  // MULT and DIV (op[0] == 0) work on magnitudes
  assign sgn_op = ~op[0];
  assign a_neg  = sgn_op & a[WIDTH-1];
  assign b_neg  = sgn_op & b[WIDTH-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MD_IDLE: if (start) state_d = MD_RUN;
      MD_RUN:  if (core_last) state_d = MD_FIX;
      MD_FIX:  state_d = MD_DONE;
      MD_DONE: state_d = MD_IDLE;
    endcase
  end

  mips_muldiv_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .load_i (accept),
    .step_i (state_q == MD_RUN),
    .div_i  (op[1]),
    .a_i    (a_mag),
    .b_i    (b_mag),
    .hi_o   (core_hi),
    .lo_o   (core_lo),
    .last_o (core_last)
  );

  // Sign fixups; neg_q/rsgn_q are only ever set for signed ops
  always_comb begin
    prod   = {core_hi, core_lo};
    prod_s = neg_q ? -prod : prod;
    res_hi = prod_s[2*WIDTH-1:WIDTH];
    res_lo = prod_s[WIDTH-1:0];
    res_we = 1'b1;
    res_dz = 1'b0;
`ifdef MIPS_MULDIV_DIV_EN
    quo = neg_q ? -core_lo : core_lo;
    rem = rsgn_q ? -core_hi : core_hi;
    if (div_q) begin
      res_hi = rem;
      res_lo = bz_q ? '1 : quo;
      res_dz = bz_q;
    end
`else
    if (div_q) res_we = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MIPS_MULDIV_DIV_EN
      rsgn_q  <= 1'b0;
      bz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        div_q  <= op[1];
        neg_q  <= a_neg ^ b_neg;
`ifdef MIPS_MULDIV_DIV_EN
        rsgn_q <= a_neg;
        bz_q   <= (b == '0);
`endif
      end
      if (idle && hi_we) hi_q <= wdata;
      if (idle && lo_we) lo_q <= wdata;
      if (state_q == MD_FIX) begin
        dz_q <= res_dz;
        if (res_we) begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
      end
    end
  end

  assign busy     = ~idle;
  assign done     = (state_q == MD_DONE);
  assign div_zero = done & dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit at WIDTH = 16.
// Vector table plus hand sequences; results flow through a scoreboard queue.
module tb_mips_muldiv_unit;
  import mips_pkg::*;

`ifdef MIPS_MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a, b, wdata;
  logic        hi_we, lo_we;
  logic        busy, done, div_zero;
  logic [15:0] hi, lo;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] hi;
    logic [15:0] lo;
    logic        dz;
  } vec_t;

  typedef struct {
    logic [15:0] hi;
    logic [15:0] lo;
    logic        dz;
  } exp_t;

  exp_t        sb[$];
  vec_t        tab[12];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] mhi, mlo;

  always #5 clk = ~clk;

  mips_muldiv_unit #(
    .WIDTH (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input vec_t v);
    exp_t e;
    if (v.op[1] && !DIV_EN) begin
      e.hi = mhi;
      e.lo = mlo;
      e.dz = 1'b0;
    end else begin
      e.hi = v.hi;
      e.lo = v.lo;
      e.dz = v.dz;
    end
    mhi = e.hi;
    mlo = e.lo;
    sb.push_back(e);
  endtask

  // Entered and left at posedge+1 with the unit idle.
  task automatic run_op(input vec_t v, input bit mthi, input bit disturb);
    int   n;
    int   busy_bad;
    exp_t e;
    op    = v.op;
    a     = v.a;
    b     = v.b;
    start = 1'b1;
    if (mthi) begin
      hi_we = 1'b1;
      wdata = 16'hBEEF;
      mhi   = 16'hBEEF;
    end
    push(v);
    @(posedge clk); #1;
    start = 1'b0;
    hi_we = 1'b0;
    if (mthi) chk("mthi_with_start", hi, 16'hBEEF);
    n = 0;
    busy_bad = 0;
    while (!done && n < 40) begin
      if (!busy) busy_bad++;
      if (disturb && n == 5) begin
        start = 1'b1;
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 16'hAAAA;
        op    = MD_DIVU;
        a     = 16'h0001;
        b     = 16'h0000;
      end
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      hi_we = 1'b0;
      lo_we = 1'b0;
    end
    chk("latency", n, 17);
    chk("busy_run", busy_bad, 0);
    chk("busy_done_cycle", busy, 1'b1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("hi", hi, e.hi);
      chk("lo", lo, e.lo);
      chk("div_zero", div_zero, e.dz);
    end else begin
      chk("scoreboard_empty", 0, 1);
    end
    @(posedge clk); #1;
    chk("done_pulse", done, 1'b0);
    chk("busy_end", busy, 1'b0);
    chk("div_zero_end", div_zero, 1'b0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    tab[0]  = '{MD_MULTU, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0};
    tab[1]  = '{MD_MULT,  16'hFFFD, 16'h0005, 16'hFFFF, 16'hFFF1, 1'b0};
    tab[2]  = '{MD_DIV,   16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0};
    tab[3]  = '{MD_DIV,   16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0};
    tab[4]  = '{MD_DIVU,  16'h0064, 16'h0000, 16'h0064, 16'hFFFF, 1'b1};
    tab[5]  = '{MD_MULTU, 16'h0003, 16'h0004, 16'h0000, 16'h000C, 1'b0};
    tab[6]  = '{MD_DIVU,  16'h0064, 16'h0007, 16'h0002, 16'h000E, 1'b0};
    tab[7]  = '{MD_MULT,  16'h8000, 16'h8000, 16'h4000, 16'h0000, 1'b0};
    tab[8]  = '{MD_DIV,   16'h0007, 16'hFFFE, 16'h0001, 16'hFFFD, 1'b0};
    tab[9]  = '{MD_DIV,   16'hFFF9, 16'h0000, 16'hFFF9, 16'hFFFF, 1'b1};
    tab[10] = '{MD_MULT,  16'h1234, 16'hFFFF, 16'hFFFF, 16'hEDCC, 1'b0};
    tab[11] = '{MD_MULTU, 16'h1234, 16'h5678, 16'h0626, 16'h0060, 1'b0};

    reset = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = '0;
    mhi   = '0;
    mlo   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_div_zero", div_zero, 1'b0);
    chk("rst_hi", hi, 16'h0000);
    chk("rst_lo", lo, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      run_op(tab[i], 1'b0, 1'b0);
      if (i == 1) begin
        lo_we = 1'b1;
        wdata = 16'h1234;
        @(posedge clk); #1;
        lo_we = 1'b0;
        mlo   = 16'h1234;
        chk("mtlo_lo", lo, mlo);
        chk("mtlo_hi", hi, mhi);
      end
    end

    // Mid-RUN start/MTHI/MTLO must not disturb the result
    v = '{MD_MULTU, 16'h1234, 16'h5678, 16'h0626, 16'h0060, 1'b0};
    run_op(v, 1'b0, 1'b1);

    // MTHI with start lands, then the result overwrites it
    v = '{MD_MULT, 16'hFFFD, 16'h0005, 16'hFFFF, 16'hFFF1, 1'b0};
    run_op(v, 1'b1, 1'b0);

    // Asynchronous abort at RUN cycle 7
    op    = MD_MULTU;
    a     = 16'hFFFF;
    b     = 16'hFFFF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("pre_abort_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_hi", hi, 16'h0000);
    chk("abort_lo", lo, 16'h0000);
    mhi = '0;
    mlo = '0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    v = '{MD_MULTU, 16'h0003, 16'h0004, 16'h0000, 16'h000C, 1'b0};
    run_op(v, 1'b0, 1'b0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
